// File: rtl/ha_resp_checker_if.sv
// Stimulus/response bundle between the half-adder test driver and its checker.
// Carries the run control pulse, the a/b vector and the DUT's sum/carry reply.
// master drives everything; the checker only observes.
interface ha_resp_checker_if;
  logic start;
  logic vec_valid;
  logic a;
  logic b;
  logic sum;
  logic carry;

  modport master (output start, output vec_valid, output a, output b, output sum, output carry);
  modport slave  (input  start, input  vec_valid, input  a, input  b, input  sum, input  carry);
endinterface

// File: rtl/ha_resp_checker.sv
// Response checker for the half-adder: aligns a/b with sum/carry and scores each vector.
// Latency: a/b to score update is PIPE cycles of alignment plus one registered cycle.
// No backpressure: every valid vector in RUN is taken; vectors outside RUN are dropped.
module ha_resp_checker #(
  parameter int CNT_W = 8,
  parameter int PIPE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  ha_resp_checker_if.slave   stim,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [3:0]         cov,
  output logic               err_sticky,
  output logic [1:0]         first_fail_vec,
  output logic [1:0]         first_fail_got
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic        in_v;
  logic        enter_run;
  logic        al_v;
  logic [1:0]  al_ab;
  logic        line_next_empty;
  logic [1:0]  exp_sc;
  logic [1:0]  got_sc;
  logic [3:0]  cov_nxt;

  assign in_v      = stim.vec_valid && (state == S_RUN);
  assign enter_run = stim.start && ((state == S_IDLE) || (state == S_DONE));

  generate
    if (PIPE == 0) begin : g_nopipe
      // No DUT latency: score the vector presented this cycle.
      assign al_v            = in_v;
      assign al_ab           = {stim.a, stim.b};
      assign line_next_empty = 1'b1;
    end else begin : g_pipe
      // Each stage holds {valid, a, b}; the last stage lines up with sum/carry.
      logic [2:0] line [PIPE];

      // Shift captured vectors toward the compare point; start of a run flushes.
      always_ff @(posedge clk) begin
        if (rst || enter_run) begin
          for (int i = 0; i < PIPE; i++) line[i] <= 3'b000;
        end else begin
          line[0] <= {in_v, stim.a, stim.b};
          for (int i = 1; i < PIPE; i++) line[i] <= line[i-1];
        end
      end

      assign al_v  = line[PIPE-1][2];
      assign al_ab = line[PIPE-1][1:0];

      // The line is empty after this edge when nothing enters and no earlier stage is valid
      // (the last stage is being scored now).
      always_comb begin
        line_next_empty = !in_v;
        for (int i = 0; i < PIPE - 1; i++) begin
          if (line[i][2]) line_next_empty = 1'b0;
        end
      end
    end
  endgenerate

  assign exp_sc  = {al_ab[1] ^ al_ab[0], al_ab[1] & al_ab[0]};
  assign got_sc  = {stim.sum, stim.carry};
  assign cov_nxt = al_v ? (cov | (4'b0001 << al_ab)) : cov;

  // Run control plus scoring. Once coverage completes, DRAIN is entered only if vectors
  // are still in flight; otherwise the run finishes straight away.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      cov            <= 4'h0;
      err_sticky     <= 1'b0;
      first_fail_vec <= 2'b00;
      first_fail_got <= 2'b00;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (stim.start) begin
            state          <= S_RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            cov            <= 4'h0;
            err_sticky     <= 1'b0;
            first_fail_vec <= 2'b00;
            first_fail_got <= 2'b00;
          end
        end
        S_RUN, S_DRAIN: begin
          if (al_v) begin
            cov <= cov_nxt;
            if (got_sc == exp_sc) begin
              if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
            end else begin
              if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
              if (!err_sticky) begin
                err_sticky     <= 1'b1;
                first_fail_vec <= al_ab;
                first_fail_got <= got_sc;
              end
            end
          end
          if ((state == S_RUN) && (cov_nxt == 4'hF)) begin
            if (line_next_empty) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else if ((state == S_DRAIN) && line_next_empty) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ha_resp_checker.sv
// Bench for ha_resp_checker: three instances (PIPE=0/CNT_W=8, PIPE=2/CNT_W=8, PIPE=0/CNT_W=2)
// share one stimulus stream; a vector-calendar model predicts every output each cycle,
// and literal checks pin the model at the interesting points.
module tb_ha_resp_checker;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0, vec_valid = 1'b0, a = 1'b0, b = 1'b0;
  logic fs = 1'b0, fc = 1'b0;  // fault injection on sum / carry
  logic [1:0] d1, d2;          // 2-cycle delayed DUT reply for the PIPE=2 instance

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;
  int cyc = 0;

  ha_resp_checker_if if0 ();
  ha_resp_checker_if if1 ();
  ha_resp_checker_if if2 ();

  assign if0.start = start; assign if0.vec_valid = vec_valid; assign if0.a = a; assign if0.b = b;
  assign if1.start = start; assign if1.vec_valid = vec_valid; assign if1.a = a; assign if1.b = b;
  assign if2.start = start; assign if2.vec_valid = vec_valid; assign if2.a = a; assign if2.b = b;
  assign if0.sum = (a ^ b) ^ fs;  assign if0.carry = (a & b) ^ fc;
  assign if2.sum = (a ^ b) ^ fs;  assign if2.carry = (a & b) ^ fc;
  assign if1.sum = d2[1];         assign if1.carry = d2[0];

  always @(posedge clk) begin
    d1 <= {(a ^ b) ^ fs, (a & b) ^ fc};
    d2 <= d1;
  end

  wire       busy_w [3];
  wire       done_w [3];
  wire [7:0] pass_w [3];
  wire [7:0] fail_w [3];
  wire [3:0] cov_w  [3];
  wire       err_w  [3];
  wire [1:0] ffv_w  [3];
  wire [1:0] ffg_w  [3];
  wire [1:0] p2, f2;
  assign pass_w[2] = {6'b0, p2};
  assign fail_w[2] = {6'b0, f2};

  ha_resp_checker #(.CNT_W(8), .PIPE(0)) u0 (
    .clk(clk), .rst(rst), .stim(if0.slave), .busy(busy_w[0]), .done(done_w[0]),
    .pass_cnt(pass_w[0]), .fail_cnt(fail_w[0]), .cov(cov_w[0]), .err_sticky(err_w[0]),
    .first_fail_vec(ffv_w[0]), .first_fail_got(ffg_w[0]));
  ha_resp_checker #(.CNT_W(8), .PIPE(2)) u1 (
    .clk(clk), .rst(rst), .stim(if1.slave), .busy(busy_w[1]), .done(done_w[1]),
    .pass_cnt(pass_w[1]), .fail_cnt(fail_w[1]), .cov(cov_w[1]), .err_sticky(err_w[1]),
    .first_fail_vec(ffv_w[1]), .first_fail_got(ffg_w[1]));
  ha_resp_checker #(.CNT_W(2), .PIPE(0)) u2 (
    .clk(clk), .rst(rst), .stim(if2.slave), .busy(busy_w[2]), .done(done_w[2]),
    .pass_cnt(p2), .fail_cnt(f2), .cov(cov_w[2]), .err_sticky(err_w[2]),
    .first_fail_vec(ffv_w[2]), .first_fail_got(ffg_w[2]));

  // ---------------- model: per instance, a calendar of vectors due for scoring ----------
  int         m_pipe [3] = '{0, 2, 0};
  int         m_max  [3] = '{255, 255, 3};
  int         mph    [3];
  int         mpass  [3];
  int         mfail  [3];
  logic [3:0] mcov   [3];
  logic       merr   [3];
  logic [1:0] mffv   [3];
  logic [1:0] mffg   [3];
  bit         sv     [3][4];
  logic [1:0] sab    [3][4];
  logic [1:0] sgot   [3][4];

  function automatic bit pending(input int k);
    bit p = 0;
    for (int s = 0; s < 4; s++) if (sv[k][s]) p = 1;
    return p;
  endfunction

  task automatic mclear(input int k);
    mpass[k] = 0; mfail[k] = 0; mcov[k] = 4'h0; merr[k] = 1'b0;
    mffv[k] = 2'b00; mffg[k] = 2'b00;
    for (int s = 0; s < 4; s++) sv[k][s] = 0;
  endtask

  task automatic model_edge(input int k);
    int slot;
    logic [1:0] ab, expv;
    if (rst) begin
      mclear(k);
      mph[k] = M_IDLE;
    end else if (start && (mph[k] == M_IDLE || mph[k] == M_DONE)) begin
      mclear(k);
      mph[k] = M_RUN;
    end else if (mph[k] == M_RUN || mph[k] == M_DRAIN) begin
      if (mph[k] == M_RUN && vec_valid) begin
        slot = (cyc + m_pipe[k]) % 4;
        sv[k][slot] = 1;
        sab[k][slot] = {a, b};
        sgot[k][slot] = {(a ^ b) ^ fs, (a & b) ^ fc};
      end
      slot = cyc % 4;
      if (sv[k][slot]) begin
        sv[k][slot] = 0;
        ab = sab[k][slot];
        expv = {ab[1] ^ ab[0], ab[1] & ab[0]};
        if (sgot[k][slot] == expv) begin
          if (mpass[k] < m_max[k]) mpass[k]++;
        end else begin
          if (mfail[k] < m_max[k]) mfail[k]++;
          if (!merr[k]) begin
            merr[k] = 1'b1; mffv[k] = ab; mffg[k] = sgot[k][slot];
          end
        end
        mcov[k][ab] = 1'b1;
      end
      if (mph[k] == M_RUN && mcov[k] == 4'hF) mph[k] = pending(k) ? M_DRAIN : M_DONE;
      else if (mph[k] == M_DRAIN && !pending(k)) mph[k] = M_DONE;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_edge(k);
    cyc++;
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s u%0d at cycle %0d: got %0h, want %0h", nm, k, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("busy", k, 32'(busy_w[k]), (mph[k] == M_RUN || mph[k] == M_DRAIN) ? 1 : 0);
        chk("done", k, 32'(done_w[k]), (mph[k] == M_DONE) ? 1 : 0);
        chk("pass_cnt", k, 32'(pass_w[k]), mpass[k]);
        chk("fail_cnt", k, 32'(fail_w[k]), mfail[k]);
        chk("cov", k, 32'(cov_w[k]), 32'(mcov[k]));
        chk("err_sticky", k, 32'(err_w[k]), 32'(merr[k]));
        chk("first_fail_vec", k, 32'(ffv_w[k]), 32'(mffv[k]));
        chk("first_fail_got", k, 32'(ffg_w[k]), 32'(mffg[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic vec(input logic [1:0] ab, input logic [1:0] flt);
    vec_valid = 1'b1; {a, b} = ab; {fs, fc} = flt;
    tick();
    vec_valid = 1'b0; fs = 1'b0; fc = 1'b0;
  endtask

  initial begin
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 0, 32'(busy_w[0]), 0);
    chk("rst_pass", 1, 32'(pass_w[1]), 0);

    // all four vectors, all correct
    pulse_start();
    vec(2'b00, 2'b00); vec(2'b01, 2'b00); vec(2'b10, 2'b00); vec(2'b11, 2'b00);
    @(negedge clk);
    chk("t1_done", 0, 32'(done_w[0]), 1);
    chk("t1_pass", 0, 32'(pass_w[0]), 4);
    chk("t1_cov", 0, 32'(cov_w[0]), 32'hF);
    chk("t1_p2_busy", 1, 32'(busy_w[1]), 1);
    chk("t1_sat_pass", 2, 32'(pass_w[2]), 3);
    tick();
    @(negedge clk);
    chk("t3_done_early", 1, 32'(done_w[1]), 0);
    tick();
    @(negedge clk);
    chk("t3_done", 1, 32'(done_w[1]), 1);
    chk("t3_busy", 1, 32'(busy_w[1]), 0);
    chk("t3_pass", 1, 32'(pass_w[1]), 4);

    // restart from DONE, then saturation run with a start pulse ignored mid-run
    pulse_start();
    @(negedge clk);
    chk("t6_busy", 0, 32'(busy_w[0]), 1);
    chk("t6_pass_clr", 0, 32'(pass_w[0]), 0);
    chk("t6_cov_clr", 1, 32'(cov_w[1]), 0);
    vec(2'b00, 2'b00); vec(2'b00, 2'b00);
    start = 1'b1; vec(2'b00, 2'b00); start = 1'b0;
    vec(2'b00, 2'b00); vec(2'b00, 2'b00); vec(2'b00, 2'b00);
    vec(2'b01, 2'b00); vec(2'b10, 2'b00); vec(2'b11, 2'b00);
    @(negedge clk);
    chk("t4_sat", 2, 32'(pass_w[2]), 3);
    chk("t4_done", 2, 32'(done_w[2]), 1);
    chk("t6_ignored", 0, 32'(pass_w[0]), 9);
    tick(); tick();
    @(negedge clk);
    chk("t4_p2_pass", 1, 32'(pass_w[1]), 9);

    // failures: first on 11 (got 10), later on 01 only counts
    pulse_start();
    vec(2'b11, 2'b11); vec(2'b00, 2'b00); vec(2'b01, 2'b01); vec(2'b10, 2'b00);
    @(negedge clk);
    chk("t2_fail", 0, 32'(fail_w[0]), 2);
    chk("t2_pass", 0, 32'(pass_w[0]), 2);
    chk("t2_err", 0, 32'(err_w[0]), 1);
    chk("t2_ffv", 0, 32'(ffv_w[0]), 32'h3);
    chk("t2_ffg", 0, 32'(ffg_w[0]), 32'h2);
    tick(); tick();
    @(negedge clk);
    chk("t2_p2_ffg", 1, 32'(ffg_w[1]), 32'h2);
    chk("t2_p2_fail", 1, 32'(fail_w[1]), 2);

    // reset mid-run, then vectors without start
    pulse_start();
    vec(2'b00, 2'b00); vec(2'b01, 2'b00);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", 1, 32'(busy_w[1]), 0);
    chk("t5_cov", 0, 32'(cov_w[0]), 0);
    chk("t5_pass", 0, 32'(pass_w[0]), 0);
    vec(2'b00, 2'b00); vec(2'b01, 2'b00); vec(2'b10, 2'b00); vec(2'b11, 2'b00);
    tick(); tick();
    @(negedge clk);
    chk("t5_nocount", 1, 32'(pass_w[1]), 0);
    chk("t5_idle", 0, 32'(busy_w[0]), 0);

    // start and rst together: rst wins
    start = 1'b1; rst = 1'b1; tick(); start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_wins", 0, 32'(busy_w[0]), 0);

    // in-flight vectors after coverage completes are drained and counted
    pulse_start();
    vec(2'b00, 2'b00); vec(2'b01, 2'b00); vec(2'b10, 2'b00); vec(2'b11, 2'b00);
    vec(2'b00, 2'b00); vec(2'b01, 2'b00);
    @(negedge clk);
    chk("drain_busy", 1, 32'(busy_w[1]), 1);
    chk("drain_ignored", 0, 32'(pass_w[0]), 4);
    tick(); tick();
    @(negedge clk);
    chk("drain_done", 1, 32'(done_w[1]), 1);
    chk("drain_pass", 1, 32'(pass_w[1]), 6);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
